// File: rtl/frost32_mem_arbiter_pkg.sv
// Shared types for the frost32 memory arbiter: FSM states, bus access encodings
// and the access legality rule used when a request is granted.
package frost32_mem_arbiter_pkg;

    localparam int ARB_STATE_MSB_POS = 1;

    typedef enum logic [ARB_STATE_MSB_POS:0] {
        StArbIdle  = 2'd0,
        StArbFetch = 2'd1,
        StArbData  = 2'd2,
        StArbResp  = 2'd3
    } ArbState;

    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    typedef enum logic [1:0] {
        Dias32  = 2'd0,
        Dias16  = 2'd1,
        Dias8   = 2'd2,
        DiasBad = 2'd3
    } DataInoutAccessSize;

    // Natural alignment is required; the reserved size encoding is never legal.
    function automatic logic access_legal(input logic [31:0] addr,
                                          input DataInoutAccessSize size);
        logic ok;
        case (size)
            Dias32:  ok = (addr[1:0] == 2'b00);
            Dias16:  ok = (addr[0] == 1'b0);
            Dias8:   ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/frost32_mem_arbiter.sv
// Arbitrates the frost32 instruction-fetch and data ports onto one memory bus,
// with bounded data bursts ahead of a waiting fetch and a per-access timeout.
module frost32_mem_arbiter
    import frost32_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int DATA_BURST_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_access_type,
    input  logic [1:0]  d_access_size,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_out,
    output logic        mem_access_type,
    output logic [1:0]  mem_access_size,
    output logic        busy
);

    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BURST_W = $clog2(DATA_BURST_LIMIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DATA_BURST_LIMIT);

    ArbState             state_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [BURST_W-1:0]  burst_cnt_r;

    // Arbitration FSM; the mem_* outputs double as the latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= StArbIdle;
            wait_cnt_r      <= '0;
            burst_cnt_r     <= '0;
            if_ack          <= 1'b0;
            if_err          <= 1'b0;
            if_data         <= 32'd0;
            d_ack           <= 1'b0;
            d_err           <= 1'b0;
            d_rdata         <= 32'd0;
            mem_req         <= 1'b0;
            mem_addr        <= 32'd0;
            mem_data_out    <= 32'd0;
            mem_access_type <= 1'b0;
            mem_access_size <= 2'd0;
            busy            <= 1'b0;
        end else begin
            if (!if_req) begin
                burst_cnt_r <= '0;
            end
            case (state_r)
                StArbIdle: begin
                    wait_cnt_r <= '0;
                    if (d_req && !(if_req && burst_cnt_r == BURST_MAX)) begin
                        if (if_req) begin
                            burst_cnt_r <= (burst_cnt_r == BURST_MAX) ? BURST_MAX
                                                                      : burst_cnt_r + BURST_W'(1);
                        end else begin
                            burst_cnt_r <= '0;
                        end
                        busy <= 1'b1;
                        if (access_legal(d_addr, DataInoutAccessSize'(d_access_size))) begin
                            state_r         <= StArbData;
                            mem_req         <= 1'b1;
                            mem_addr        <= d_addr;
                            mem_data_out    <= (d_access_type == DiatWrite) ? d_wdata : 32'd0;
                            mem_access_type <= d_access_type;
                            mem_access_size <= d_access_size;
                        end else begin
                            state_r <= StArbResp;
                            d_ack   <= 1'b1;
                            d_err   <= 1'b1;
                        end
                    end else if (if_req) begin
                        burst_cnt_r <= '0;
                        busy        <= 1'b1;
                        if (if_addr[1:0] == 2'b00) begin
                            state_r         <= StArbFetch;
                            mem_req         <= 1'b1;
                            mem_addr        <= if_addr;
                            mem_data_out    <= 32'd0;
                            mem_access_type <= DiatRead;
                            mem_access_size <= Dias32;
                        end else begin
                            state_r <= StArbResp;
                            if_ack  <= 1'b1;
                            if_err  <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StArbFetch, StArbData: begin
                    if (mem_ready || wait_cnt_r == WAIT_LAST) begin
                        state_r         <= StArbResp;
                        mem_req         <= 1'b0;
                        mem_addr        <= 32'd0;
                        mem_data_out    <= 32'd0;
                        mem_access_type <= 1'b0;
                        mem_access_size <= 2'd0;
                        // A ready on the final allowed cycle still counts as success.
                        if (state_r == StArbFetch) begin
                            if_ack  <= 1'b1;
                            if_err  <= !mem_ready;
                            if_data <= mem_ready ? mem_data_in : 32'd0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_err   <= !mem_ready;
                            d_rdata <= (mem_ready && mem_access_type == DiatRead) ? mem_data_in
                                                                                  : 32'd0;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                StArbResp: begin
                    state_r <= StArbIdle;
                    busy    <= 1'b0;
                    if_ack  <= 1'b0;
                    if_err  <= 1'b0;
                    if_data <= 32'd0;
                    d_ack   <= 1'b0;
                    d_err   <= 1'b0;
                    d_rdata <= 32'd0;
                end
                default: begin
                    state_r <= StArbIdle;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    if_ack  <= 1'b0;
                    d_ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Scoreboard bench for frost32_mem_arbiter: drivers queue expected responses,
// a monitor checks every ack, and a memory responder checks the shared bus.
module tb_frost32_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ack, if_err;
    logic [31:0] if_data;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
    logic        d_access_type = 1'b0;
    logic [1:0]  d_access_size = 2'd0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic [31:0] mem_data_in = 32'd0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr, mem_data_out;
    logic        mem_access_type;
    logic [1:0]  mem_access_size;
    logic        busy;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       f_q[$];
    resp_t       d_q[$];
    int          grant_log[$];
    int          checks = 0;
    int          errors = 0;
    int          mem_mode = 0;     // 0 random, 1 always ready, 2 never, 3 ready on 3rd cycle, 4 const data
    int          mem_cnt = 0;
    logic [31:0] const_data = 32'd0;

    always #5 clk = ~clk;

    frost32_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_data(if_data),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_access_type(d_access_type),
        .d_access_size(d_access_size), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_access_type(mem_access_type),
        .mem_access_size(mem_access_size), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic resp_t model_fetch(input logic [31:0] a);
        resp_t r;
        r.err  = (a[1:0] != 2'b00);
        r.data = r.err ? 32'd0 : mem_word(a);
        return r;
    endfunction

    function automatic resp_t model_data(input logic [31:0] a, input logic wr, input logic [1:0] sz);
        resp_t r;
        logic  legal;
        legal  = (sz == 2'd2) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd0 && a[1:0] == 2'b00);
        r.err  = !legal;
        r.data = (!legal || wr) ? 32'd0 : mem_word(a);
        return r;
    endfunction

    task automatic wait_ack(input int which, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!((which == 1) ? d_ack : if_ack) && lat < 400);
        if (lat >= 400) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port=%0d waited=%0d required=<400", which, lat);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a);
        int lat;
        if_addr = a;
        if_req  = 1'b1;
        f_q.push_back(model_fetch(a));
        wait_ack(0, lat);
    endtask

    task automatic do_data(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                           input logic [1:0] sz);
        int lat;
        d_addr        = a;
        d_wdata       = wd;
        d_access_type = wr;
        d_access_size = sz;
        d_req         = 1'b1;
        d_q.push_back(model_data(a, wr, sz));
        wait_ack(1, lat);
    endtask

    // Monitor: pop and compare on every ack, enforce quiet outputs otherwise.
    always @(negedge clk) begin
        resp_t e;
        chk("ack_exclusive", {63'd0, if_ack & d_ack}, 64'd0);
        if (if_ack) begin
            grant_log.push_back(1);
            if (f_q.size() == 0) begin
                chk("if_ack_unexpected", 64'd1, 64'd0);
            end else begin
                e = f_q.pop_front();
                chk("if_err", {63'd0, if_err}, {63'd0, e.err});
                chk("if_data", {32'd0, if_data}, {32'd0, e.data});
            end
        end else begin
            chk("if_quiet", {31'd0, if_err, if_data}, 64'd0);
        end
        if (d_ack) begin
            grant_log.push_back(0);
            if (d_q.size() == 0) begin
                chk("d_ack_unexpected", 64'd1, 64'd0);
            end else begin
                e = d_q.pop_front();
                chk("d_err", {63'd0, d_err}, {63'd0, e.err});
                chk("d_rdata", {32'd0, d_rdata}, {32'd0, e.data});
            end
        end else begin
            chk("d_quiet", {31'd0, d_err, d_rdata}, 64'd0);
        end
    end

    // Memory responder: checks bus fields against a held request, then answers.
    always @(posedge clk) begin
        logic ok_f, ok_d;
        #1;
        if (!rst_n) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_req) begin
            ok_f = if_req && mem_addr == if_addr && mem_access_type == 1'b0 &&
                   mem_access_size == 2'd0 && mem_data_out == 32'd0;
            ok_d = d_req && mem_addr == d_addr && mem_access_type == d_access_type &&
                   mem_access_size == d_access_size &&
                   mem_data_out == (d_access_type ? d_wdata : 32'd0);
            chk("mem_bus_fields", {63'd0, ok_f | ok_d}, 64'd1);
            mem_cnt++;
            case (mem_mode)
                0:       mem_ready = ($urandom_range(0, 1) == 1);
                1:       mem_ready = 1'b1;
                2:       mem_ready = 1'b0;
                3:       mem_ready = (mem_cnt == 3);
                default: mem_ready = 1'b1;
            endcase
            mem_data_in = (mem_mode == 4) ? const_data : mem_word(mem_addr);
        end else begin
            mem_cnt     = 0;
            mem_ready   = (mem_mode == 1) || (mem_mode == 0 && $urandom_range(0, 1) == 1);
            mem_data_in = $urandom;
        end
    end

    initial begin
        int lat;
        #1;
        chk("reset_outputs", {32'd0, if_ack, if_err, d_ack, d_err, mem_req, busy,
                              mem_access_type, mem_access_size},
            64'd0);
        chk("reset_data", {32'd0, if_data | d_rdata | mem_addr | mem_data_out}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Misaligned halfword: immediate error, no bus activity.
        d_addr = 32'h101; d_access_size = 2'd1; d_access_type = 1'b0; d_req = 1'b1;
        d_q.push_back(model_data(32'h101, 1'b0, 2'd1));
        @(posedge clk); #1;
        chk("bad16_ack_cycle1", {62'd0, d_ack, d_err}, 64'd3);
        chk("bad16_no_mem_req", {63'd0, mem_req}, 64'd0);
        d_req = 1'b0;
        @(posedge clk); #1;
        chk("bad16_no_mem_req_after", {63'd0, mem_req}, 64'd0);
        repeat (2) @(posedge clk); #1;

        // Word write with ready on the third bus cycle.
        mem_mode = 3;
        d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_access_type = 1'b1; d_access_size = 2'd0;
        d_req = 1'b1;
        d_q.push_back(model_data(32'h100, 1'b1, 2'd0));
        @(posedge clk); #1;
        chk("wr_mem_req", {63'd0, mem_req}, 64'd1);
        chk("wr_mem_addr", {32'd0, mem_addr}, 64'h100);
        chk("wr_mem_wdata", {32'd0, mem_data_out}, 64'hDEAD_BEEF);
        chk("wr_mem_type_size", {61'd0, mem_access_type, mem_access_size}, 64'd4);
        chk("wr_busy", {63'd0, busy}, 64'd1);
        wait_ack(1, lat);
        chk("wr_ack_latency", lat, 64'd3);
        d_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Fetch with no memory response times out.
        mem_mode = 2;
        if_addr = 32'h200; if_req = 1'b1;
        f_q.push_back('{err: 1'b1, data: 32'd0});
        @(posedge clk); #1;
        chk("to_mem_req", {63'd0, mem_req}, 64'd1);
        wait_ack(0, lat);
        chk("to_ack_latency", lat, 64'd255);
        if_req = 1'b0;
        @(posedge clk); #1;
        chk("to_idle_busy", {62'd0, busy, mem_req}, 64'd0);
        repeat (2) @(posedge clk); #1;

        // Both ports saturated: four data grants, then the fetch.
        mem_mode = 1;
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 2; i++) do_fetch({$urandom_range(0, 4095), 2'b00});
                if_req = 1'b0;
            end
            begin
                for (int j = 0; j < 8; j++)
                    do_data({$urandom_range(0, 4095), 2'b00}, $urandom, 1'($urandom_range(0, 1)),
                            2'd0);
                d_req = 1'b0;
            end
        join
        @(posedge clk); #1;
        chk("burst_grant_count", grant_log.size(), 64'd10);
        for (int k = 0; k < 10 && k < grant_log.size(); k++)
            chk("burst_grant_order", grant_log[k], (k % 5 == 4) ? 64'd1 : 64'd0);
        repeat (2) @(posedge clk); #1;

        // Randomized traffic with random memory latency and stray ready strobes.
        mem_mode = 0;
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                do_fetch({$urandom_range(0, 65535), 2'($urandom_range(0, 3) == 0 ? 1 : 0)});
                if_req = 1'b0;
            end
            for (int j = 0; j < 60; j++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                do_data($urandom_range(0, 262143), $urandom, 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)));
                d_req = 1'b0;
            end
        join
        repeat (3) @(posedge clk); #1;

        // Reset in the middle of a data access abandons it.
        mem_mode = 2;
        d_addr = 32'h40; d_access_type = 1'b0; d_access_size = 2'd0; d_req = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_mid_mem_req_before", {63'd0, mem_req}, 64'd1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {61'd0, mem_req, busy, d_ack}, 64'd0);
        d_req = 1'b0;
        if_addr = 32'h200; if_req = 1'b1;
        mem_mode = 4; const_data = 32'h1234_5678;
        f_q.push_back('{err: 1'b0, data: 32'h1234_5678});
        repeat (2) @(posedge clk); #1;
        chk("rst_held_quiet", {61'd0, mem_req, busy, if_ack}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(0, lat);
        chk("rst_first_fetch_latency", lat, 64'd2);
        if_req = 1'b0;
        repeat (3) @(posedge clk); #1;

        chk("queues_drained", f_q.size() + d_q.size(), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
